ireg_prefetch: RTL and testbench

- Parametrised successor to the CADR instruction register.
- Adds a DEPTH-entry prefetch queue between the instruction memory read path and IR.
- Applies IMOD substitution from IOB as each instruction is loaded into IR on a fetch.
- Sits between the I-memory/fetch unit and the decode/dispatch logic; lets fetch run ahead of execution and lets jumps flush stale prefetches.

---
 rtl/ireg_prefetch_pkg.sv | 12 +
 rtl/ireg_imod_merge.sv | 31 +++
 rtl/ireg_prefetch.sv | 113 +++++++++++
 tb/tb_ireg_prefetch.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ireg_prefetch_pkg.sv
// Shared instruction-register constants and types used by the IR, the prefetch
// queue and decode.
package ireg_prefetch_pkg;

    localparam int IW_DEF    = 49;
    localparam int IOBW_DEF  = 48;
    localparam int SPLIT_DEF = 26;
    localparam int DEPTH_DEF = 4;

    typedef logic [IW_DEF-1:0] instr_t;

endpackage

// File: rtl/ireg_imod_merge.sv
// IMOD substitution: overlays IOB onto the low and/or high instruction fields
// as a word is loaded into IR.
module ireg_imod_merge
    import ireg_prefetch_pkg::*;
#(
    parameter int IW    = IW_DEF,
    parameter int IOBW  = IOBW_DEF,
    parameter int SPLIT = SPLIT_DEF
) (
    input  logic [IW-1:0]   i_src,
    input  logic [IOBW-1:0] i_iob,
    input  logic            i_destimod0,
    input  logic            i_destimod1,
    output logic [IW-1:0]   o_merged
);

    logic [IOBW-1:0] w_low_mid;

    assign w_low_mid[SPLIT-1:0]    = i_destimod0 ? i_iob[SPLIT-1:0]    : i_src[SPLIT-1:0];
    assign w_low_mid[IOBW-1:SPLIT] = i_destimod1 ? i_iob[IOBW-1:SPLIT] : i_src[IOBW-1:SPLIT];

    // Bits above the IOB width exist only when IR is wider than IOB; they clear on a high IMOD.
    generate
        if (IW > IOBW) begin : g_wide
            assign o_merged = {(i_destimod1 ? {(IW-IOBW){1'b0}} : i_src[IW-1:IOBW]), w_low_mid};
        end else begin : g_narrow
            assign o_merged = w_low_mid;
        end
    endgenerate

endmodule

// File: rtl/ireg_prefetch.sv
// Instruction register fed by a DEPTH-entry prefetch queue with empty-queue
// bypass, jump flush and IMOD substitution on load.
module ireg_prefetch
    import ireg_prefetch_pkg::*;
#(
    parameter int IW    = IW_DEF,
    parameter int IOBW  = IOBW_DEF,
    parameter int SPLIT = SPLIT_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int CW   = $clog2(DEPTH+1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [IW-1:0]   in_i,
    output logic            in_ready,
    input  logic            fetch,
    input  logic            flush,
    input  logic [IOBW-1:0] iob,
    input  logic            destimod0,
    input  logic            destimod1,
    output logic [IW-1:0]   ir,
    output logic            ir_valid,
    output logic [CW-1:0]   count
);

    logic [IW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [IW-1:0] r_ir;
    logic          r_ir_valid;

    logic          w_full;
    logic          w_empty;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;
    logic          w_load;
    logic [IW-1:0] w_src;
    logic [IW-1:0] w_merged;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign in_ready = ~w_full;

    // A word bypassed straight into IR on an empty queue is consumed, never enqueued.
    assign w_bypass = w_empty & in_valid & fetch & ~flush;
    assign w_push   = in_valid & ~w_full & ~flush & ~w_bypass;
    assign w_pop    = fetch & ~w_empty & ~flush;
    assign w_load   = w_pop | w_bypass;
    assign w_src    = w_empty ? in_i : r_mem[r_rd_ptr];

    ireg_imod_merge #(
        .IW    (IW),
        .IOBW  (IOBW),
        .SPLIT (SPLIT)
    ) u_merge (
        .i_src       (w_src),
        .i_iob       (iob),
        .i_destimod0 (destimod0),
        .i_destimod1 (destimod1),
        .o_merged    (w_merged)
    );

    // NOTE: queue storage has no reset; occupancy and pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
        end else if (flush) begin
            r_count  <= '0;
            r_rd_ptr <= r_wr_ptr;
            if (fetch) begin
                r_ir_valid <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (fetch) begin
                r_ir_valid <= w_load;
                if (w_load) begin
                    r_ir <= w_merged;
                end
            end
        end
    end

    assign ir       = r_ir;
    assign ir_valid = r_ir_valid;
    assign count    = r_count;

endmodule

// File: tb/tb_ireg_prefetch.sv
// Self-checking bench for ireg_prefetch: directed vector table followed by
// randomized traffic compared against a queue-based reference model.
module tb_ireg_prefetch;
    import ireg_prefetch_pkg::*;

    localparam int IW    = 49;
    localparam int IOBW  = 48;
    localparam int SPLIT = 26;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic [IW-1:0]   in_i;
    logic            in_ready;
    logic            fetch;
    logic            flush;
    logic [IOBW-1:0] iob;
    logic            destimod0;
    logic            destimod1;
    logic [IW-1:0]   ir;
    logic            ir_valid;
    logic [CW-1:0]   count;

    always #5 clk = ~clk;

    ireg_prefetch #(.IW(IW), .IOBW(IOBW), .SPLIT(SPLIT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_i      (in_i),
        .in_ready  (in_ready),
        .fetch     (fetch),
        .flush     (flush),
        .iob       (iob),
        .destimod0 (destimod0),
        .destimod1 (destimod1),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .count     (count)
    );

    typedef struct {
        logic            rst;
        logic            iv;
        instr_t          din;
        logic            fe;
        logic            fl;
        logic [IOBW-1:0] iob;
        logic            d0;
        logic            d1;
        instr_t          e_ir;
        logic            e_v;
        int              e_cnt;
        logic            e_rdy;
    } vec_t;

    vec_t   vecs[$];
    int     n_pass  = 0;
    int     n_total = 0;

    // Reference model: plain FIFO of words plus IR state.
    instr_t m_q[$];
    instr_t m_ir;
    logic   m_v;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic instr_t imod(input instr_t src, input logic [IOBW-1:0] b,
                                    input logic d0, input logic d1);
        logic [63:0] lo_mask;
        logic [63:0] iob_mask;
        logic [63:0] r;
        lo_mask  = (64'd1 << SPLIT) - 64'd1;
        iob_mask = (64'd1 << IOBW) - 64'd1;
        r = 64'(src);
        if (d0) r = (r & ~lo_mask) | (64'(b) & lo_mask);
        if (d1) r = (r & lo_mask) | (64'(b) & iob_mask & ~lo_mask);
        return instr_t'(r);
    endfunction

    task automatic model_step(input vec_t v);
        bit was_empty;
        bit was_full;
        was_empty = (m_q.size() == 0);
        was_full  = (m_q.size() == DEPTH);
        if (v.rst) begin
            m_q.delete();
            m_ir = '0;
            m_v  = 1'b0;
        end else if (v.fl) begin
            m_q.delete();
            if (v.fe) m_v = 1'b0;
        end else begin
            if (v.fe) begin
                if (!was_empty) begin
                    m_ir = imod(m_q.pop_front(), v.iob, v.d0, v.d1);
                    m_v  = 1'b1;
                end else if (v.iv) begin
                    m_ir = imod(v.din, v.iob, v.d0, v.d1);
                    m_v  = 1'b1;
                end else begin
                    m_v = 1'b0;
                end
            end
            if (v.iv && !was_full && !(was_empty && v.fe)) m_q.push_back(v.din);
        end
    endtask

    task automatic apply(input vec_t v);
        reset     = v.rst;
        in_valid  = v.iv;
        in_i      = v.din;
        fetch     = v.fe;
        flush     = v.fl;
        iob       = v.iob;
        destimod0 = v.d0;
        destimod1 = v.d1;
        @(posedge clk);
        model_step(v);
        #1;
    endtask

    task automatic add(input logic rst, input logic iv, input instr_t din, input logic fe,
                       input logic fl, input logic [IOBW-1:0] b, input logic d0, input logic d1,
                       input instr_t e_ir, input logic e_v, input int e_cnt, input logic e_rdy);
        vec_t v;
        v.rst = rst; v.iv = iv; v.din = din; v.fe = fe; v.fl = fl;
        v.iob = b; v.d0 = d0; v.d1 = d1;
        v.e_ir = e_ir; v.e_v = e_v; v.e_cnt = e_cnt; v.e_rdy = e_rdy;
        vecs.push_back(v);
    endtask

    localparam instr_t W_A  = 49'h1_0000_0000_0001;
    localparam instr_t W_B  = 49'h0_0000_0000_0002;
    localparam instr_t W_C  = 49'h1_2345_6789_ABCD;
    localparam instr_t W_D  = 49'h1_FFFF_FFFF_FFFF;
    localparam instr_t W_D1 = 49'h0_AAAA_ABFF_FFFF;
    localparam instr_t W_C0 = 49'h1_2345_6678_9ABC;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_i = '0; fetch = 1'b0; flush = 1'b0;
        iob = '0; destimod0 = 1'b0; destimod1 = 1'b0;
        m_ir = '0; m_v = 1'b0;

        //   rst iv  din          fe  fl  iob                d0  d1   ir     v  cnt rdy
        add(1, 0, '0,            0, 0, '0,                0, 0,   '0,    0, 0, 1);
        add(0, 0, '0,            1, 0, '0,                0, 0,   '0,    0, 0, 1);
        add(0, 1, W_A,           0, 0, '0,                0, 0,   '0,    0, 1, 1);
        add(0, 1, W_B,           0, 0, '0,                0, 0,   '0,    0, 2, 1);
        add(0, 1, W_C,           0, 0, '0,                0, 0,   '0,    0, 3, 1);
        add(0, 0, '0,            1, 0, '0,                0, 0,   W_A,   1, 2, 1);
        add(0, 0, '0,            1, 0, '0,                0, 0,   W_B,   1, 1, 1);
        add(0, 0, '0,            1, 0, '0,                0, 0,   W_C,   1, 0, 1);
        add(0, 1, W_D,           0, 0, '0,                0, 0,   W_C,   1, 1, 1);
        add(0, 0, '0,            1, 0, 48'hAAAA_AAAA_AAAA, 0, 1,  W_D1,  1, 0, 1);
        for (int k = 0; k < DEPTH; k++)
            add(0, 1, instr_t'(49'h11 + k), 0, 0, '0, 0, 0, W_D1, 1, k + 1, (k + 1) != DEPTH);
        // Full: the offered word is refused even though a pop happens.
        add(0, 1, 49'h99,        1, 0, '0,                0, 0,   49'h11, 1, 3, 1);
        // Steady push+pop wraps both pointers.
        for (int k = 0; k < 8; k++)
            add(0, 1, instr_t'(49'h100 + k), 1, 0, '0, 0, 0,
                (k < 3) ? instr_t'(49'h12 + k) : instr_t'(49'h100 + k - 3), 1, 3, 1);
        for (int k = 0; k < 3; k++)
            add(0, 0, '0, 1, 0, '0, 0, 0, instr_t'(49'h105 + k), 1, 2 - k, 1);
        add(0, 1, 49'h42,        1, 0, '0,                0, 0,   49'h42, 1, 0, 1);
        add(0, 1, W_C,           0, 0, '0,                0, 0,   49'h42, 1, 1, 1);
        add(0, 0, '0,            1, 0, 48'h1234_5678_9ABC, 1, 0,  W_C0,  1, 0, 1);
        add(0, 1, 49'h61,        0, 0, '0,                0, 0,   W_C0,  1, 1, 1);
        add(0, 1, 49'h62,        0, 1, '0,                0, 0,   W_C0,  1, 0, 1);
        for (int k = 0; k < 3; k++)
            add(0, 1, instr_t'(49'h51 + k), 0, 0, '0, 0, 0, W_C0, 1, k + 1, 1);
        add(0, 1, 49'h77,        1, 1, '0,                0, 0,   W_C0,  0, 0, 1);
        add(0, 0, '0,            1, 0, '0,                0, 0,   W_C0,  0, 0, 1);
        add(0, 1, 49'h88,        0, 0, '0,                0, 0,   W_C0,  0, 1, 1);
        add(0, 0, '0,            1, 0, '0,                0, 0,   49'h88, 1, 0, 1);
        add(0, 1, 49'h5,         0, 0, '0,                0, 0,   49'h88, 1, 1, 1);
        add(1, 1, 49'h6,         1, 0, '0,                0, 0,   '0,    0, 0, 1);

        foreach (vecs[i]) begin
            apply(vecs[i]);
            check($sformatf("vec%0d ir", i),       64'(ir),       64'(vecs[i].e_ir));
            check($sformatf("vec%0d ir_valid", i), 64'(ir_valid), 64'(vecs[i].e_v));
            check($sformatf("vec%0d count", i),    64'(count),    64'(vecs[i].e_cnt));
            check($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(vecs[i].e_rdy));
        end

        for (int c = 0; c < 600; c++) begin
            vec_t v;
            v.rst = (c == 0) || ($urandom_range(0, 99) == 0);
            v.iv  = $urandom_range(0, 99) < 60;
            v.din = {17'($urandom), 32'($urandom)};
            v.fe  = $urandom_range(0, 99) < 45;
            v.fl  = $urandom_range(0, 99) < 6;
            v.iob = {16'($urandom), 32'($urandom)};
            v.d0  = $urandom_range(0, 3) == 0;
            v.d1  = $urandom_range(0, 3) == 0;
            apply(v);
            check($sformatf("rnd%0d ir", c),       64'(ir),       64'(m_ir));
            check($sformatf("rnd%0d ir_valid", c), 64'(ir_valid), 64'(m_v));
            check($sformatf("rnd%0d count", c),    64'(count),    64'(m_q.size()));
            check($sformatf("rnd%0d in_ready", c), 64'(in_ready), 64'(m_q.size() != DEPTH));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
